// File: rtl/reg_pipeline_pkg.sv
// Shared constants and helpers for the WIDTH x DEPTH register pipeline.
package reg_pipeline_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    // Width of a counter that must hold 0..depth inclusive.
    function automatic int occ_w(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/reg_pipeline_if.sv
// Data/control bundle of reg_pipeline; notQ exists only with REG_PIPELINE_NOTQ_EN.
interface reg_pipeline_if
    import reg_pipeline_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
);

    logic [WIDTH-1:0]        D;
    logic                    inValid;
    logic                    enable;
    logic                    flush;
    logic [WIDTH-1:0]        Q;
    logic                    outValid;
    logic [occ_w(DEPTH)-1:0] occupancy;
`ifdef REG_PIPELINE_NOTQ_EN
    logic [WIDTH-1:0]        notQ;

    modport master (output D, inValid, enable, flush,
                    input  Q, outValid, occupancy, notQ);
    modport slave  (input  D, inValid, enable, flush,
                    output Q, outValid, occupancy, notQ);
`else
    modport master (output D, inValid, enable, flush,
                    input  Q, outValid, occupancy);
    modport slave  (input  D, inValid, enable, flush,
                    output Q, outValid, occupancy);
`endif

endinterface

// File: rtl/reg_pipeline_stage.sv
// One pipeline stage: WIDTH data bits plus a valid bit. Flush clears only the
// valid bit so the data register keeps its contents.
module reg_stage
    import reg_pipeline_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             syncReset,
    input  logic             enable_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             valid_i,
    output logic [WIDTH-1:0] q_o,
    output logic             valid_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             valid_q;
    logic             valid_d;

    // Next-state: flush beats enable, otherwise hold.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (enable_i) begin
            data_d  = d_i;
            valid_d = valid_i;
        end else begin
            data_d  = data_q;
            valid_d = valid_q;
        end
    end

    // Stage register with synchronous reset.
    always_ff @(posedge clk) begin
        if (syncReset) begin
            data_q  <= RESET_VAL;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign q_o     = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/reg_pipeline.sv
// WIDTH-bit, DEPTH-stage delay line with valid bits, stall, flush and a
// registered occupancy count. Optional notQ output: define REG_PIPELINE_NOTQ_EN.
module reg_pipeline
    import reg_pipeline_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter int               DEPTH     = DEF_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic         clk,
    input  logic         syncReset,
    reg_pipeline_if.slave bus
);

    localparam int OCC_W = occ_w(DEPTH);

    logic [WIDTH-1:0] stage_data  [DEPTH];
    logic             stage_valid [DEPTH];
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        if (g == 0) begin : g_head
            reg_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
                .clk      (clk),
                .syncReset(syncReset),
                .enable_i (bus.enable),
                .flush_i  (bus.flush),
                .d_i      (bus.D),
                .valid_i  (bus.inValid),
                .q_o      (stage_data[g]),
                .valid_o  (stage_valid[g])
            );
        end else begin : g_body
            reg_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
                .clk      (clk),
                .syncReset(syncReset),
                .enable_i (bus.enable),
                .flush_i  (bus.flush),
                .d_i      (stage_data[g-1]),
                .valid_i  (stage_valid[g-1]),
                .q_o      (stage_data[g]),
                .valid_o  (stage_valid[g])
            );
        end
    end

    // Incremental count: one in from D, one out from the last stage per enabled edge.
    always_comb begin
        occ_d = occ_q;
        if (bus.flush) begin
            occ_d = {OCC_W{1'b0}};
        end else if (bus.enable) begin
            occ_d = occ_q + OCC_W'(bus.inValid) - OCC_W'(stage_valid[DEPTH-1]);
        end else begin
            occ_d = occ_q;
        end
    end

    // Occupancy register with synchronous reset.
    always_ff @(posedge clk) begin
        if (syncReset) begin
            occ_q <= {OCC_W{1'b0}};
        end else begin
            occ_q <= occ_d;
        end
    end

    assign bus.Q         = stage_data[DEPTH-1];
    assign bus.outValid  = stage_valid[DEPTH-1];
    assign bus.occupancy = occ_q;
`ifdef REG_PIPELINE_NOTQ_EN
    assign bus.notQ      = ~stage_data[DEPTH-1];
`endif

endmodule

// File: tb/tb_reg_pipeline.sv
// Directed bench: an 8x4 pipeline (RESET_VAL 8'hA5) and a 1x1 pipeline (RESET_VAL 1).
module tb_reg_pipeline;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    reg_pipeline_if #(.WIDTH(8), .DEPTH(4)) pa ();
    reg_pipeline_if #(.WIDTH(1), .DEPTH(1)) pb ();

    reg_pipeline #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'hA5)) u_dut_a (
        .clk      (clk),
        .syncReset(rst),
        .bus      (pa)
    );

    reg_pipeline #(.WIDTH(1), .DEPTH(1), .RESET_VAL(1'b1)) u_dut_b (
        .clk      (clk),
        .syncReset(rst),
        .bus      (pb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic en, input logic fl, input logic v, input logic [7:0] d);
        pa.enable  = en;
        pa.flush   = fl;
        pa.inValid = v;
        pa.D       = d;
    endtask

    task automatic drive_b(input logic en, input logic fl, input logic v, input logic d);
        pb.enable  = en;
        pb.flush   = fl;
        pb.inValid = v;
        pb.D       = d;
    endtask

    task automatic check_b(input string tag, input logic q, input logic v, input logic occ);
        check({tag, "_q"}, 32'(pb.Q), 32'(q));
        check({tag, "_v"}, 32'(pb.outValid), 32'(v));
        check({tag, "_occ"}, 32'(pb.occupancy), 32'(occ));
`ifdef REG_PIPELINE_NOTQ_EN
        check({tag, "_notq"}, 32'(pb.notQ), 32'(~q));
`endif
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        drive_a(1'b1, 1'b0, 1'b1, 8'hFF);
        drive_b(1'b1, 1'b0, 1'b1, 1'b0);

        // 1: reset with junk on the inputs
        tick();
        tick();
        check("rst_q", 32'(pa.Q), 32'h0000_00A5);
        check("rst_v", 32'(pa.outValid), 32'h0000_0000);
        check("rst_occ", 32'(pa.occupancy), 32'h0000_0000);
`ifdef REG_PIPELINE_NOTQ_EN
        check("rst_notq", 32'(pa.notQ), 32'h0000_005A);
`endif
        check_b("b_rst", 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        drive_b(1'b0, 1'b0, 1'b0, 1'b0);

        // 2: stream 1..5 then bubbles
        for (int i = 1; i <= 9; i++) begin
            drive_a(1'b1, 1'b0, (i <= 5) ? 1'b1 : 1'b0, (i <= 5) ? 8'(i) : 8'h00);
            tick();
            check("str_occ", 32'(pa.occupancy), (i <= 4) ? 32'(i) : 32'(9 - i));
            check("str_v", 32'(pa.outValid), (i >= 4 && i <= 8) ? 32'h1 : 32'h0);
            if (i >= 4 && i <= 8) begin
                check("str_q", 32'(pa.Q), 32'(i - 3));
            end
        end

        // 3: load 11,22, move them to the tail, stall, resume
        drive_a(1'b1, 1'b0, 1'b1, 8'h11); tick();
        drive_a(1'b1, 1'b0, 1'b1, 8'h22); tick();
        drive_a(1'b1, 1'b0, 1'b0, 8'h00); tick();
        tick();
        check("pre_stall_q", 32'(pa.Q), 32'h0000_0011);
        check("pre_stall_occ", 32'(pa.occupancy), 32'h0000_0002);
        for (int i = 0; i < 3; i++) begin
            drive_a(1'b0, 1'b0, 1'b1, 8'(8'h33 + 8'(i * 17)));
            tick();
            check("stall_q", 32'(pa.Q), 32'h0000_0011);
            check("stall_v", 32'(pa.outValid), 32'h0000_0001);
            check("stall_occ", 32'(pa.occupancy), 32'h0000_0002);
        end
        drive_a(1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        check("resume1_q", 32'(pa.Q), 32'h0000_0022);
        check("resume1_v", 32'(pa.outValid), 32'h0000_0001);
        check("resume1_occ", 32'(pa.occupancy), 32'h0000_0001);
        tick();
        check("resume2_v", 32'(pa.outValid), 32'h0000_0000);
        check("resume2_occ", 32'(pa.occupancy), 32'h0000_0000);

        // 4: fill with 61..64, flush with a valid item offered
        for (int i = 1; i <= 4; i++) begin
            drive_a(1'b1, 1'b0, 1'b1, 8'(8'h60 + 8'(i)));
            tick();
        end
        check("full_q", 32'(pa.Q), 32'h0000_0061);
        check("full_occ", 32'(pa.occupancy), 32'h0000_0004);
        drive_a(1'b1, 1'b1, 1'b1, 8'h99);
        tick();
        check("flush_v", 32'(pa.outValid), 32'h0000_0000);
        check("flush_occ", 32'(pa.occupancy), 32'h0000_0000);
        check("flush_q", 32'(pa.Q), 32'h0000_0061);
        drive_a(1'b1, 1'b0, 1'b1, 8'h71);
        tick();
        check("postfl_occ", 32'(pa.occupancy), 32'h0000_0001);
        for (int j = 2; j <= 4; j++) begin
            drive_a(1'b1, 1'b0, 1'b0, 8'h00);
            tick();
            check("postfl_v", 32'(pa.outValid), (j == 4) ? 32'h1 : 32'h0);
        end
        check("postfl_q", 32'(pa.Q), 32'h0000_0071);
        tick();
        check("drain_occ", 32'(pa.occupancy), 32'h0000_0000);

        // 5: three items in flight, reset together with flush
        for (int i = 1; i <= 3; i++) begin
            drive_a(1'b1, 1'b0, 1'b1, 8'(8'h80 + 8'(i)));
            tick();
        end
        check("mid_occ", 32'(pa.occupancy), 32'h0000_0003);
        rst = 1'b1;
        drive_a(1'b1, 1'b1, 1'b1, 8'hEE);
        tick();
        rst = 1'b0;
        check("rstfl_q", 32'(pa.Q), 32'h0000_00A5);
        check("rstfl_v", 32'(pa.outValid), 32'h0000_0000);
        check("rstfl_occ", 32'(pa.occupancy), 32'h0000_0000);
        check_b("b_rst2", 1'b1, 1'b0, 1'b0);
        drive_a(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rstdrain_q", 32'(pa.Q), 32'h0000_00A5);
            check("rstdrain_v", 32'(pa.outValid), 32'h0000_0000);
        end

        // 6: DEPTH=1, WIDTH=1 pipeline
        drive_b(1'b1, 1'b0, 1'b1, 1'b0); tick(); check_b("b_d0", 1'b0, 1'b1, 1'b1);
        drive_b(1'b1, 1'b0, 1'b1, 1'b1); tick(); check_b("b_d1", 1'b1, 1'b1, 1'b1);
        drive_b(1'b1, 1'b0, 1'b0, 1'b0); tick(); check_b("b_bub", 1'b0, 1'b0, 1'b0);
        drive_b(1'b1, 1'b0, 1'b1, 1'b1); tick(); check_b("b_d1b", 1'b1, 1'b1, 1'b1);
        drive_b(1'b0, 1'b0, 1'b0, 1'b0); tick(); check_b("b_stall", 1'b1, 1'b1, 1'b1);
        drive_b(1'b1, 1'b1, 1'b1, 1'b0); tick(); check_b("b_flush", 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
